// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war referee: game state and winner encodings.
package tug_pkg;

    typedef enum logic [1:0] {PLAY, WIN, MATCH} tug_state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_CPU   = 2'b10;

endpackage

// File: rtl/press_edge.sv
// Turns a press level into a one-cycle registered pulse on its rising edge,
// with an optional synchronizer chain in front for asynchronous sources.
module press_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    logic synced;
    logic prev;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= level_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign synced = sync_q[SYNC_STAGES-1];
        end else begin : g_bypass
            assign synced = level_in;
        end
    endgenerate

    // The pulse is registered so both paths see one extra cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= 1'b0;
            pulse_out <= 1'b0;
        end else begin
            prev      <= synced;
            pulse_out <= synced & ~prev;
        end
    end

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: moves the lit LED on each press, scores rounds,
// holds off restarts after a win and locks the match at SCORE_MAX.
module tug_referee
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = 9,
    parameter int SCORE_W     = 3,
    parameter int SCORE_MAX   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                human_key,
    input  logic                cpu_press,
    output logic [N_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]  human_score,
    output logic [SCORE_W-1:0]  cpu_score,
    output logic                round_over,
    output logic [1:0]          winner
);

    localparam int POS_W  = $clog2(N_LIGHTS);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(N_LIGHTS - 1);
    localparam logic [POS_W-1:0]    POS_CENTRE = POS_W'(N_LIGHTS / 2);
    localparam logic [HOLD_W-1:0]   HOLD_INIT  = HOLD_W'(HOLD_CYCLES);
    localparam logic [SCORE_W-1:0]  SCORE_LAST = SCORE_W'(SCORE_MAX - 1);
    localparam logic [N_LIGHTS-1:0] LIGHT_LSB  = N_LIGHTS'(1);

    function automatic logic [N_LIGHTS-1:0] one_hot(input logic [POS_W-1:0] p);
        return LIGHT_LSB << p;
    endfunction

    tug_state_t        state;
    logic [POS_W-1:0]  pos;
    logic [HOLD_W-1:0] hold;
    logic              h_pulse;
    logic              c_pulse;

    press_edge #(.SYNC_STAGES(2)) u_human_edge (
        .clk       (clk),
        .reset     (reset),
        .level_in  (human_key),
        .pulse_out (h_pulse)
    );

    press_edge #(.SYNC_STAGES(0)) u_cpu_edge (
        .clk       (clk),
        .reset     (reset),
        .level_in  (cpu_press),
        .pulse_out (c_pulse)
    );

    // NOTE: every register, outputs included, is state here; all use <= so
    // each branch reads the values from before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= PLAY;
            pos         <= POS_CENTRE;
            hold        <= '0;
            lights      <= one_hot(POS_CENTRE);
            human_score <= '0;
            cpu_score   <= '0;
            round_over  <= 1'b0;
            winner      <= WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (h_pulse && !c_pulse) begin
                        if (pos == POS_LAST) begin
                            human_score <= human_score + 1'b1;
                            winner      <= WIN_HUMAN;
                            round_over  <= 1'b1;
                            hold        <= HOLD_INIT;
                            if (human_score == SCORE_LAST) begin
                                state  <= MATCH;
                                lights <= '1;
                            end else begin
                                state  <= WIN;
                                lights <= '0;
                            end
                        end else begin
                            pos    <= pos + 1'b1;
                            lights <= one_hot(pos + 1'b1);
                        end
                    end else if (c_pulse && !h_pulse) begin
                        if (pos == '0) begin
                            cpu_score  <= cpu_score + 1'b1;
                            winner     <= WIN_CPU;
                            round_over <= 1'b1;
                            hold       <= HOLD_INIT;
                            if (cpu_score == SCORE_LAST) begin
                                state  <= MATCH;
                                lights <= '1;
                            end else begin
                                state  <= WIN;
                                lights <= '0;
                            end
                        end else begin
                            pos    <= pos - 1'b1;
                            lights <= one_hot(pos - 1'b1);
                        end
                    end
                end
                WIN: begin
                    // Only the human restarts a round, and only once the hold expires.
                    if (hold != '0) begin
                        hold <= hold - 1'b1;
                    end else if (h_pulse) begin
                        state      <= PLAY;
                        pos        <= POS_CENTRE;
                        lights     <= one_hot(POS_CENTRE);
                        round_over <= 1'b0;
                    end
                end
                MATCH: ;
                default: state <= PLAY;
            endcase
        end
    end

endmodule
